// File: rtl/vram_pixel_writer_if.sv
// Draw-command and framebuffer RAM bus for vram_pixel_writer.
// The slave modport is the writer's view; the master modport is the command source plus the RAM.
interface vram_pixel_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  px_x;
  logic [7:0]  px_y;
  logic [5:0]  px_color;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;

  modport slave (
    input  cmd_valid, px_x, px_y, px_color, mem_rdata,
    output cmd_ready, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cmd_valid, px_x, px_y, px_color, mem_rdata,
    input  cmd_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vram_pixel_writer.sv
// Packs single-pixel draw commands into two-pixel framebuffer words by read-modify-write.
// Defining VRAM_WRITER_FILL_EN adds a whole-framebuffer fill with a fill_done pulse.
module vram_pixel_writer #(
  parameter int unsigned MEM_WIDTH       = 32,
  parameter int unsigned MEM_HEIGHT      = 24,
  parameter int unsigned MEM_ADDR_OFFSET = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  vram_pixel_writer_if.slave    bus,
  output logic                  busy,
  output logic                  err
`ifdef VRAM_WRITER_FILL_EN
  ,
  input  logic                  fill_start,
  input  logic [5:0]            fill_color,
  output logic                  fill_done
`endif
);

`ifdef VRAM_WRITER_FILL_EN
  localparam int unsigned FILL_WORDS = MEM_WIDTH * MEM_HEIGHT;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MG,
    WR
`ifdef VRAM_WRITER_FILL_EN
    ,
    FILL
`endif
  } state_t;

  state_t      state;
  logic        hi_sel;
  logic [5:0]  color_q;
  logic [15:0] word_addr;
  logic        out_of_range;
  logic        accept;
`ifdef VRAM_WRITER_FILL_EN
  logic [31:0] fill_cnt;
  logic [15:0] fill_word;
`endif

  always_comb begin
    word_addr    = 16'(MEM_ADDR_OFFSET + 32'(bus.px_y) * MEM_WIDTH + 32'(bus.px_x >> 1));
    out_of_range = (32'(bus.px_x) >= 2 * MEM_WIDTH) || (32'(bus.px_y) >= MEM_HEIGHT);
  end

`ifdef VRAM_WRITER_FILL_EN
  assign bus.cmd_ready = (state == IDLE) && !clear && !fill_start;
`else
  assign bus.cmd_ready = (state == IDLE) && !clear;
`endif
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      bus.mem_addr  <= 16'(MEM_ADDR_OFFSET);
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      err           <= 1'b0;
      hi_sel        <= 1'b0;
      color_q       <= '0;
`ifdef VRAM_WRITER_FILL_EN
      fill_cnt      <= '0;
      fill_word     <= '0;
      fill_done     <= 1'b0;
`endif
    end else begin
`ifdef VRAM_WRITER_FILL_EN
      fill_done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          bus.mem_we <= 1'b0;
`ifdef VRAM_WRITER_FILL_EN
          if (fill_start) begin
            fill_word     <= {2'b00, fill_color, 2'b00, fill_color};
            bus.mem_wdata <= {2'b00, fill_color, 2'b00, fill_color};
            bus.mem_addr  <= 16'(MEM_ADDR_OFFSET);
            bus.mem_we    <= 1'b1;
            fill_cnt      <= 32'd1;
            state         <= FILL;
          end else
`endif
          if (accept) begin
            // Dropped commands only flag err; mem_addr keeps its last value.
            if (out_of_range) begin
              err <= 1'b1;
            end else begin
              hi_sel       <= ~bus.px_x[0];
              color_q      <= bus.px_color;
              bus.mem_addr <= word_addr;
              state        <= RD;
            end
          end
        end
        RD: state <= MG;
        MG: begin
          bus.mem_wdata <= hi_sel ? {2'b00, color_q, bus.mem_rdata[7:0]}
                                  : {bus.mem_rdata[15:8], 2'b00, color_q};
          bus.mem_we    <= 1'b1;
          state         <= WR;
        end
        WR: begin
          bus.mem_we <= 1'b0;
          state      <= IDLE;
        end
`ifdef VRAM_WRITER_FILL_EN
        FILL: begin
          if (fill_cnt == FILL_WORDS) begin
            bus.mem_we <= 1'b0;
            fill_done  <= 1'b1;
            state      <= IDLE;
          end else begin
            bus.mem_addr  <= bus.mem_addr + 16'd1;
            bus.mem_wdata <= fill_word;
            fill_cnt      <= fill_cnt + 32'd1;
          end
        end
`endif
        default: begin
          bus.mem_we <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Directed bench for vram_pixel_writer: RAM model, shadow-memory scoreboard of expected writes.
module tb_vram_pixel_writer;
  localparam int unsigned W   = 32;
  localparam int unsigned H   = 24;
  localparam int unsigned OFF = 0;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic busy;
  logic err;
`ifdef VRAM_WRITER_FILL_EN
  logic       fill_start = 1'b0;
  logic [5:0] fill_color = '0;
  logic       fill_done;
`endif

  vram_pixel_writer_if bus ();

  vram_pixel_writer #(
    .MEM_WIDTH(W),
    .MEM_HEIGHT(H),
    .MEM_ADDR_OFFSET(OFF)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus),
    .busy(busy),
    .err(err)
`ifdef VRAM_WRITER_FILL_EN
    ,
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fill_done(fill_done)
`endif
  );

  always #5 clock = ~clock;

  logic [15:0] ram    [0:65535];
  logic [15:0] shadow [0:65535];
  logic        pre_we   = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clock) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(bus.mem_addr), 32'(mon_e[31:16]));
        check("write_data", 32'(bus.mem_wdata), 32'(mon_e[15:0]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr  = a;
    pre_data  = d;
    pre_we    = 1'b1;
    shadow[a] = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic expect_px(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
    logic [15:0] a;
    logic [15:0] old;
    logic [15:0] nw;
    a   = 16'(OFF + 32'(y) * W + 32'(x) / 2);
    old = shadow[a];
    nw  = x[0] ? {old[15:8], 2'b00, c} : {2'b00, c, old[7:0]};
    shadow[a] = nw;
    exp_q.push_back({a, nw});
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("ready_timeout", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic draw(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c,
                      input bit legal);
    wait_ready();
    bus.px_x      = x;
    bus.px_y      = y;
    bus.px_color  = c;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    if (legal) expect_px(x, y, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] bx [3];
  logic [7:0] by [3];
  logic [5:0] bc [3];
  int         idx;
  int         last_acc;
  bit         rdy;
`ifdef VRAM_WRITER_FILL_EN
  int         done_cnt;
  bit         acc;
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.px_x      = '0;
    bus.px_y      = '0;
    bus.px_color  = '0;
    repeat (3) step();

    check("rst_addr", 32'(bus.mem_addr), OFF);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);

    preload(16'd0, 16'hABCD);
    preload(16'd70, 16'h3F3F);
    preload(16'd34, 16'h1234);
    preload(16'd767, 16'h0F0F);
    preload(16'd5, 16'h5555);
    clear = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Even-x draw with cycle-exact timing.
    bus.px_x = 8'd0; bus.px_y = 8'd0; bus.px_color = 6'h15;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    expect_px(8'd0, 8'd0, 6'h15);
    check("t0_busy", 32'(busy), 32'd1);
    check("t0_ready", 32'(bus.cmd_ready), 32'd0);
    check("t0_addr", 32'(bus.mem_addr), 32'd0);
    step();
    check("t1_we", 32'(bus.mem_we), 32'd0);
    step();
    check("t2_we", 32'(bus.mem_we), 32'd1);
    check("t2_wdata", 32'(bus.mem_wdata), 32'h15CD);
    check("t2_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    check("t3_we", 32'(bus.mem_we), 32'd0);
    check("t3_ready", 32'(bus.cmd_ready), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_addr_hold", 32'(bus.mem_addr), 32'd0);

    // Odd-x draw on row 2.
    draw(8'd13, 8'd2, 6'h2A, 1'b1);
    repeat (4) step();
    check("odd_addr_hold", 32'(bus.mem_addr), 32'd70);

    // Out-of-range commands are swallowed and flag err.
    draw(8'd64, 8'd0, 6'h01, 1'b0);
    check("oor_err", 32'(err), 32'd1);
    check("oor_ready", 32'(bus.cmd_ready), 32'd1);
    check("oor_busy", 32'(busy), 32'd0);
    draw(8'd0, 8'd24, 6'h02, 1'b0);
    repeat (5) step();
    check("oor_err_sticky", 32'(err), 32'd1);

    // Back-to-back with cmd_valid held; two hits on the same word test ordering.
    bx[0] = 8'd4;  by[0] = 8'd1;  bc[0] = 6'h01;
    bx[1] = 8'd5;  by[1] = 8'd1;  bc[1] = 6'h3E;
    bx[2] = 8'd63; by[2] = 8'd23; bc[2] = 6'h22;
    idx = 0;
    last_acc = -1;
    wait_ready();
    bus.px_x = bx[0]; bus.px_y = by[0]; bus.px_color = bc[0];
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rdy = bus.cmd_ready;
      step();
      if (rdy) begin
        expect_px(bx[idx], by[idx], bc[idx]);
        if (idx > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
        idx++;
        if (idx == 3) begin
          bus.cmd_valid = 1'b0;
          break;
        end
        bus.px_x = bx[idx]; bus.px_y = by[idx]; bus.px_color = bc[idx];
      end
    end
    bus.cmd_valid = 1'b0;
    check("b2b_count", 32'(idx), 32'd3);
    repeat (5) step();
    check("err_survives_draws", 32'(err), 32'd1);

    // clear during MG abandons the write.
    draw(8'd10, 8'd0, 6'h3C, 1'b0);
    step();
    clear = 1'b1;
    check("abort_mg_we", 32'(bus.mem_we), 32'd0);
    step();
    check("abort_we", 32'(bus.mem_we), 32'd0);
    check("abort_addr", 32'(bus.mem_addr), OFF);
    check("abort_wdata", 32'(bus.mem_wdata), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(bus.cmd_ready), 32'd0);
    clear = 1'b0;
    repeat (6) step();
    check("abort_ram", 32'(ram[5]), 32'(shadow[5]));

    check("ram_w0", 32'(ram[0]), 32'h15CD);
    check("ram_w70", 32'(ram[70]), 32'h3F2A);
    check("ram_w34", 32'(ram[34]), 32'h013E);
    check("ram_w767", 32'(ram[767]), 32'h0F22);

`ifdef VRAM_WRITER_FILL_EN
    // Fill wins over a simultaneous command; the command follows fill_done.
    wait_ready();
    fill_color = 6'h3F;
    fill_start = 1'b1;
    bus.px_x = 8'd2; bus.px_y = 8'd0; bus.px_color = 6'h11;
    bus.cmd_valid = 1'b1;
    #1;
    check("fill_priority", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < int'(W * H); i++) begin
      exp_q.push_back({16'(OFF + 32'(i)), 16'h3F3F});
      shadow[16'(OFF + 32'(i))] = 16'h3F3F;
    end
    step();
    fill_start = 1'b0;
    check("fill_busy", 32'(busy), 32'd1);
    done_cnt = 0;
    acc = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (fill_done) done_cnt++;
      if (bus.cmd_ready) begin
        check("fill_cmd_after_done", 32'(done_cnt), 32'd1);
        step();
        expect_px(8'd2, 8'd0, 6'h11);
        bus.cmd_valid = 1'b0;
        acc = 1'b1;
        break;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    check("fill_cmd_accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (fill_done) done_cnt++;
      step();
    end
    check("fill_done_pulses", 32'(done_cnt), 32'd1);
    check("fill_ram_last", 32'(ram[16'(OFF + W * H - 1)]), 32'h3F3F);
    check("fill_ram_cmd", 32'(ram[16'(OFF + 1)]), 32'h113F);
`endif

    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
